// File: rtl/vt100_pkg.sv
// Shared constants for the VT100 byte-stream decoder: opcodes, special bytes,
// FSM state encoding and small decode helpers.
package vt100_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUTC = 4'd1;
  localparam logic [3:0] OP_CR   = 4'd2;
  localparam logic [3:0] OP_LF   = 4'd3;
  localparam logic [3:0] OP_BS   = 4'd4;
  localparam logic [3:0] OP_TAB  = 4'd5;
  localparam logic [3:0] OP_CUP  = 4'd6;
  localparam logic [3:0] OP_CUU  = 4'd7;
  localparam logic [3:0] OP_CUD  = 4'd8;
  localparam logic [3:0] OP_CUF  = 4'd9;
  localparam logic [3:0] OP_CUB  = 4'd10;
  localparam logic [3:0] OP_ED   = 4'd11;
  localparam logic [3:0] OP_EL   = 4'd12;
  localparam logic [3:0] OP_RIS  = 4'd13;

  localparam logic [7:0] ESC      = 8'h1B;
  localparam logic [7:0] CAN      = 8'h18;
  localparam logic [7:0] SUB      = 8'h1A;
  localparam logic [7:0] LBRACKET = 8'h5B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2
  } state_e;

  // C0 controls that map directly to a command; NOP for everything else.
  function automatic logic [3:0] ctrl_op(input logic [7:0] b);
    case (b)
      8'h0D:   return OP_CR;
      8'h0A:   return OP_LF;
      8'h08:   return OP_BS;
      8'h09:   return OP_TAB;
      default: return OP_NOP;
    endcase
  endfunction

  // 1-based parameter (0 meaning default 1) to 0-based coordinate, clamped.
  function automatic logic [7:0] cup_coord(input logic [7:0] p, input logic [7:0] lim);
    logic [7:0] v;
    v = (p == 8'd0) ? 8'd0 : p - 8'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/vt100_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the parser and the
// terminal buffer.
interface vt100_parser_if;
  logic [7:0] i_byte;
  logic       i_byte_v;
  logic [3:0] o_op;
  logic [7:0] o_arg0;
  logic [7:0] o_arg1;
  logic       o_cmd_v;

  modport slave  (input  i_byte, i_byte_v, output o_op, o_arg0, o_arg1, o_cmd_v);
  modport master (output i_byte, i_byte_v, input  o_op, o_arg0, o_arg1, o_cmd_v);
endinterface

// File: rtl/vt100_param_acc.sv
// Two-slot saturating decimal accumulator for CSI parameters; slot index
// advances on ';' and stops at 2 so extra parameters are dropped.
module vt100_param_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       digit_i,
  input  logic [3:0] digit_val_i,
  input  logic       sep_i,
  output logic [7:0] p0_o,
  output logic [7:0] p1_o
);

  logic [7:0]  p0_q, p0_d, p1_q, p1_d;
  logic [1:0]  pidx_q, pidx_d;
  logic [7:0]  cur;
  logic [11:0] wide;
  logic [7:0]  sat;

  always_comb begin
    cur  = (pidx_q == 2'd0) ? p0_q : p1_q;
    wide = {4'd0, cur} * 12'd10 + {8'd0, digit_val_i};
    sat  = (wide > 12'd255) ? 8'd255 : wide[7:0];
  end

  always_comb begin
    p0_d   = p0_q;
    p1_d   = p1_q;
    pidx_d = pidx_q;
    if (clr_i) begin
      p0_d   = 8'd0;
      p1_d   = 8'd0;
      pidx_d = 2'd0;
    end else if (digit_i) begin
      if (pidx_q == 2'd0)      p0_d = sat;
      else if (pidx_q == 2'd1) p1_d = sat;
    end else if (sep_i) begin
      if (pidx_q != 2'd2) pidx_d = pidx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q   <= 8'd0;
      p1_q   <= 8'd0;
      pidx_q <= 2'd0;
    end else begin
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      pidx_q <= pidx_d;
    end
  end

  assign p0_o = p0_q;
  assign p1_o = p1_q;

endmodule

// File: rtl/vt100_parser.sv
// VT100 subset decoder: turns received bytes into terminal-buffer commands,
// one registered command strobe per completing byte.
//
// state    | meaning
// ST_IDLE  | ground state: printables and C0 controls
// ST_ESC   | ESC seen, waiting for '[' or 'c'
// ST_CSI   | inside ESC[ ... collecting params until a final byte
module vt100_parser
  import vt100_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 24
) (
  input  logic           clk,
  input  logic           rst,
  vt100_parser_if.slave  bus
);

  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
  localparam logic [7:0] COL_MAX = 8'(COLS - 1);

  state_e     state_q, state_d;
  logic       ign_q, ign_d;
  logic       cmd_v_q, cmd_v_d;
  logic [3:0] op_q, op_d;
  logic [7:0] arg0_q, arg0_d, arg1_q, arg1_d;
  logic       acc_clr, acc_digit, acc_sep;
  logic [7:0] p0, p1;
  logic [7:0] b;
  logic       is_final, is_digit, is_ign;

  assign b        = bus.i_byte;
  assign is_final = (b >= 8'h40) && (b <= 8'h7E);
  assign is_digit = (b >= 8'h30) && (b <= 8'h39);
  assign is_ign   = ((b >= 8'h3C) && (b <= 8'h3F)) || ((b >= 8'h20) && (b <= 8'h2F));

  vt100_param_acc u_acc (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (acc_clr),
    .digit_i     (acc_digit),
    .digit_val_i (b[3:0]),
    .sep_i       (acc_sep),
    .p0_o        (p0),
    .p1_o        (p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ign_q   <= 1'b0;
      cmd_v_q <= 1'b0;
      op_q    <= OP_NOP;
      arg0_q  <= 8'd0;
      arg1_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ign_q   <= ign_d;
      cmd_v_q <= cmd_v_d;
      op_q    <= op_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ign_d     = ign_q;
    acc_clr   = 1'b0;
    acc_digit = 1'b0;
    acc_sep   = 1'b0;
    if (bus.i_byte_v) begin
      case (state_q)
        ST_IDLE: if (b == ESC) state_d = ST_ESC;
        ST_ESC: begin
          if (b == LBRACKET) begin
            state_d = ST_CSI;
            ign_d   = 1'b0;
            acc_clr = 1'b1;
          end else if (b != ESC) begin
            state_d = ST_IDLE;
          end
        end
        ST_CSI: begin
          if (b == ESC)                    state_d = ST_ESC;
          else if (b == CAN || b == SUB)   state_d = ST_IDLE;
          else if (is_final)               state_d = ST_IDLE;
          else if (is_digit)               acc_digit = 1'b1;
          else if (b == 8'h3B)             acc_sep = 1'b1;
          else if (is_ign)                 ign_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_v_d = 1'b0;
    op_d    = op_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    if (bus.i_byte_v) begin
      case (state_q)
        ST_IDLE: begin
          if (b >= 8'h20 && b <= 8'h7E) begin
            cmd_v_d = 1'b1;
            op_d    = OP_PUTC;
            arg0_d  = b;
            arg1_d  = 8'd0;
          end else if (ctrl_op(b) != OP_NOP) begin
            cmd_v_d = 1'b1;
            op_d    = ctrl_op(b);
            arg0_d  = 8'd0;
            arg1_d  = 8'd0;
          end
        end
        ST_ESC: begin
          if (b == 8'h63) begin
            cmd_v_d = 1'b1;
            op_d    = OP_RIS;
            arg0_d  = 8'd0;
            arg1_d  = 8'd0;
          end
        end
        ST_CSI: begin
          // Controls embedded in a sequence execute without disturbing it.
          if (ctrl_op(b) != OP_NOP) begin
            cmd_v_d = 1'b1;
            op_d    = ctrl_op(b);
            arg0_d  = 8'd0;
            arg1_d  = 8'd0;
          end else if (is_final && !ign_q) begin
            case (b)
              8'h48, 8'h66: begin
                cmd_v_d = 1'b1;
                op_d    = OP_CUP;
                arg0_d  = cup_coord(p0, ROW_MAX);
                arg1_d  = cup_coord(p1, COL_MAX);
              end
              8'h41, 8'h42, 8'h43, 8'h44: begin
                cmd_v_d = 1'b1;
                op_d    = OP_CUU + {2'd0, b[1:0] - 2'd1};
                arg0_d  = (p0 == 8'd0) ? 8'd1 : p0;
                arg1_d  = 8'd0;
              end
              8'h4A, 8'h4B: begin
                if (p0 <= 8'd2) begin
                  cmd_v_d = 1'b1;
                  op_d    = (b == 8'h4A) ? OP_ED : OP_EL;
                  arg0_d  = p0;
                  arg1_d  = 8'd0;
                end
              end
              default: cmd_v_d = 1'b0;
            endcase
          end
        end
        default: cmd_v_d = 1'b0;
      endcase
    end
  end

  assign bus.o_cmd_v = cmd_v_q;
  assign bus.o_op    = op_q;
  assign bus.o_arg0  = arg0_q;
  assign bus.o_arg1  = arg1_q;

endmodule

// File: tb/tb_vt100_parser.sv
// Directed bench for vt100_parser: stimulus pushes expected commands into a
// queue, a monitor pops and compares each strobe including its latency.
module tb_vt100_parser;
  import vt100_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a0;
    logic [7:0] a1;
    bit         c0;
    bit         c1;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  vt100_parser_if bus ();

  vt100_parser #(.COLS(80), .ROWS(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_cmd_v) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got op=%0d a0=%0d a1=%0d, required no strobe",
                 bus.o_op, bus.o_arg0, bus.o_arg1);
      end else begin
        exp_t e;
        e = q.pop_front();
        tests++;
        if (bus.o_op !== e.op) begin
          fails++;
          $display("FAIL op: got %0d, required %0d", bus.o_op, e.op);
        end
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL latency(op %0d): got cycle %0d, required %0d", e.op, cyc, e.cyc);
        end
        if (e.c0) begin
          tests++;
          if (bus.o_arg0 !== e.a0) begin
            fails++;
            $display("FAIL arg0(op %0d): got %0d, required %0d", e.op, bus.o_arg0, e.a0);
          end
        end
        if (e.c1) begin
          tests++;
          if (bus.o_arg1 !== e.a1) begin
            fails++;
            $display("FAIL arg1(op %0d): got %0d, required %0d", e.op, bus.o_arg1, e.a1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.i_byte   = b;
    bus.i_byte_v = 1'b1;
    @(negedge clk);
    bus.i_byte_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [3:0] op,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input bit c0, input bit c1);
    exp_t e;
    @(negedge clk);
    e.op = op; e.a0 = a0; e.a1 = a1; e.c0 = c0; e.c1 = c1; e.cyc = cyc + 1;
    q.push_back(e);
    bus.i_byte   = b;
    bus.i_byte_v = 1'b1;
    @(negedge clk);
    bus.i_byte_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    bus.i_byte   = 8'h00;
    bus.i_byte_v = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_cmd_v", {7'd0, bus.o_cmd_v}, 8'd0);
    check_val("reset_op",    {4'd0, bus.o_op},    8'd0);
    check_val("reset_arg0",  bus.o_arg0,          8'd0);
    check_val("reset_arg1",  bus.o_arg1,          8'd0);
    rst = 1'b0;

    send_exp(8'h41, OP_PUTC, 8'h41, 8'd0, 1, 0);
    repeat (1000) @(negedge clk);
    send_exp(8'h0D, OP_CR, 8'd0, 8'd0, 0, 0);
    repeat (1000) @(negedge clk);
    send_exp(8'h0A, OP_LF, 8'd0, 8'd0, 0, 0);

    send(ESC); send_str("[12;40"); send_exp("H", OP_CUP, 8'd11, 8'd39, 1, 1);
    send(ESC); send("[");          send_exp("H", OP_CUP, 8'd0,  8'd0,  1, 1);
    send(ESC); send_str("[999;100"); send_exp("H", OP_CUP, 8'd23, 8'd79, 1, 1);
    send(ESC); send("[");          send_exp("C", OP_CUF, 8'd1,  8'd0,  1, 1);
    send(ESC); send_str("[0");     send_exp("A", OP_CUU, 8'd1,  8'd0,  1, 1);
    send(ESC); send_str("[7");     send_exp("D", OP_CUB, 8'd7,  8'd0,  1, 1);
    send(ESC); send_str("[2");     send_exp("J", OP_ED,  8'd2,  8'd0,  1, 0);
    send(ESC); send_str("[5J");
    check_val("arg0_hold_after_discard", bus.o_arg0, 8'd2);
    send(ESC); send("[");          send_exp("K", OP_EL,  8'd0,  8'd0,  1, 0);

    send(ESC); send_str("[?25h");
    send(ESC); send_str("[3"); send(CAN); send_exp("x", OP_PUTC, 8'h78, 8'd0, 1, 0);
    send(ESC); send_str("[1;2;3"); send_exp("H", OP_CUP, 8'd0, 8'd1, 1, 1);
    send(ESC); send_str("[;5");    send_exp("H", OP_CUP, 8'd0, 8'd4, 1, 1);

    send(ESC); send_str("[1");
    send_exp(8'h0D, OP_CR, 8'd0, 8'd0, 0, 0);
    send_str("0;5");
    send_exp("H", OP_CUP, 8'd9, 8'd4, 1, 1);

    send(ESC); send_str("[12;");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_exp("3", OP_PUTC, 8'h33, 8'd0, 1, 0);
    send_exp("H", OP_PUTC, 8'h48, 8'd0, 1, 0);

    send(ESC); send_exp("c", OP_RIS, 8'd0, 8'd0, 0, 0);

    repeat (20) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_strobes: got %0d outstanding, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vt100_parser.md
Name: vt100_parser

Overview:
- Byte-stream decoder between the UART receiver and the terminal buffer.
- Consumes raw received bytes (byte plus one-cycle valid) and emits one decoded terminal command per recognised input: printable character, C0 control, or VT100 CSI/ESC sequence.
- The terminal buffer executes the commands against its character grid.
- Handles a fixed VT100 subset; anything else is discarded silently.

Parameters:
- COLS, 80, screen width; CUP column clamp limit is COLS-1.
- ROWS, 24, screen height; CUP row clamp limit is ROWS-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_byte  in  8  received byte.
- i_byte_v  in  1  single-cycle strobe; i_byte is valid this cycle.
- o_op  out  4  command opcode.
- o_arg0  out  8  first argument.
- o_arg1  out  8  second argument.
- o_cmd_v  out  1  single-cycle strobe; o_op/o_arg0/o_arg1 are valid.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: o_cmd_v=0, o_op=NOP(0), o_arg0=0, o_arg1=0; state=IDLE; params and counters cleared. Reset mid-sequence abandons the sequence with no output.
- No backpressure: the consumer accepts every o_cmd_v.
- Latency: o_cmd_v asserts exactly 1 cycle after the i_byte_v that completes a command. At most one command per input byte.
- Outputs are registered. Args hold their value between strobes.
- Opcodes:
  - NOP=0, PUTC=1, CR=2, LF=3, BS=4, TAB=5
  - CUP=6, CUU=7, CUD=8, CUF=9, CUB=10
  - ED=11, EL=12, RIS=13
- IDLE:
  - 0x20-0x7E -> PUTC, arg0=byte.
  - 0x0D -> CR; 0x0A -> LF; 0x08 -> BS; 0x09 -> TAB.
  - 0x1B -> ESC.
  - All other bytes (other C0, 0x7F, >=0x80) are ignored.
- ESC state:
  - '[' -> CSI, clearing p0, p1, pidx and the ignore flag.
  - 'c' -> RIS, then IDLE.
  - 0x1B -> stay in ESC.
  - 0x18/0x1A -> IDLE, no output.
  - Any other byte -> IDLE, no output.
- CSI state:
  - '0'-'9': p[pidx] = p*10+digit, saturating at 255; only when pidx<2.
  - ';': pidx increments, saturating at 2; parameters beyond the second are ignored.
  - 0x3C-0x3F (private marker, e.g. '?') and 0x20-0x2F (intermediates): set the ignore flag.
  - Final byte 0x40-0x7E: decode, then IDLE. If the ignore flag is set, no output.
  - 'H' or 'f' -> CUP:
    - arg0=max(p0,1)-1, clamped to ROWS-1.
    - arg1=max(p1,1)-1, clamped to COLS-1.
  - 'A'/'B'/'C'/'D' -> CUU/CUD/CUF/CUB, arg0=max(p0,1), arg1=0.
  - 'J' -> ED, arg0=p0 if p0<=2; otherwise no output.
  - 'K' -> EL, arg0=p0 if p0<=2; otherwise no output.
  - Any other final byte -> no output.
  - 0x1B -> ESC state (restarts the sequence).
  - 0x18/0x1A -> IDLE, no output.
  - 0x0D/0x0A/0x08/0x09 -> emit the corresponding control command; CSI state and params are preserved.
  - Other C0 and 0x7F -> ignored.
- Empty parameters (e.g. "ESC[;5H") read as 0 and take the default above.
- Arithmetic: params are 8-bit unsigned, computed with a 12-bit intermediate before saturation.

Decomposition:
- Package vt100_pkg holds:
  - opcode constants NOP..RIS;
  - byte constants ESC=0x1B, CAN=0x18, SUB=0x1A, LBRACKET=0x5B;
  - state encoding IDLE/ESC/CSI.
- One natural sub-module: vt100_param_acc, the two-slot saturating decimal accumulator with pidx and clear/digit/separator inputs.
- The FSM and output register stay in vt100_parser.

Test Plan:
- Reset; bytes 0x41, 0x0D, 0x0A, spaced 1000 cycles apart -> PUTC/0x41, CR, LF; each o_cmd_v exactly 1 cycle after its i_byte_v; no other strobes.
- "ESC[12;40H" -> one CUP, arg0=11, arg1=39. "ESC[H" -> CUP 0,0. "ESC[999;100H" -> CUP 23,79 (999 saturates to 255, then clamps).
- "ESC[C" -> CUF arg0=1. "ESC[0A" -> CUU arg0=1. "ESC[7D" -> CUB arg0=7. "ESC[2J" -> ED arg0=2. "ESC[5J" -> no output. "ESC[K" -> EL arg0=0.
- "ESC[?25h" -> no output. "ESC[3", CAN, 'x' -> only PUTC 0x78. "ESC[1;2;3H" -> CUP 0,1.
- "ESC[1", 0x0D, "0;5H" -> CR, then CUP 9,4.
- "ESC[12;" then rst held 1 cycle, then "3H" -> PUTC 0x33, PUTC 0x48, no CUP. "ESC c" -> RIS.
